// File: rtl/io_uart_tx_pkg.sv
// Shared register offsets and transmit FSM state encoding for io_uart_tx.
package io_uart_tx_pkg;

  localparam logic [31:0] UART_STATUS  = 32'h0;
  localparam logic [31:0] UART_TX_DATA = 32'h4;
  localparam logic [31:0] UART_DIVISOR = 32'h8;

  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_PARITY,
    UART_STOP
  } uart_tx_state_t;

  // A divisor of 0 would make a zero-length bit; clamp it to one clock.
  function automatic logic [15:0] divisor_sanitize(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/io_bus_interface.sv
// IO bus between the core-side interconnect and its responders.
interface io_bus_interface;
  logic        write_en;
  logic        read_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport slave  (input write_en, read_en, address, write_data, output read_data);
  modport master (output write_en, read_en, address, write_data, input read_data);
endinterface

// File: rtl/io_uart_tx_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read port (data_out shows the head).
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SIZE  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(SIZE):0]    count
);

  localparam int unsigned AW = $clog2(SIZE);

  logic [WIDTH-1:0] mem [SIZE];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == (AW+1)'(SIZE));
  assign empty    = (count == '0);
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the IO bus (STATUS, TX_DATA, DIVISOR).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module io_uart_tx
  import io_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS    = 32'h40,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
  input  logic            clk,
  input  logic            reset,
  io_bus_interface.slave  io_bus,
  output logic            uart_tx
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic          sel_status;
  logic          sel_tx;
  logic          sel_div;
  logic          push_drop;
  logic          overflow;
  logic [15:0]   divisor;
  logic [31:0]   status_word;
  logic [31:0]   rd_mux;
  logic [31:0]   read_data_q;
  logic          unused_wdata;

  uart_tx_state_t state;
  logic [15:0]    bit_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           bit_end;
`ifdef UART_TX_PARITY_EN
  logic           parity_bit;
`endif

  sync_fifo #(.WIDTH(8), .SIZE(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .data_in  (io_bus.write_data[7:0]),
    .data_out (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign sel_status   = (io_bus.address == BASE_ADDRESS + UART_STATUS);
  assign sel_tx       = (io_bus.address == BASE_ADDRESS + UART_TX_DATA);
  assign sel_div      = (io_bus.address == BASE_ADDRESS + UART_DIVISOR);
  assign fifo_push    = io_bus.write_en && sel_tx && !fifo_full;
  assign push_drop    = io_bus.write_en && sel_tx && fifo_full;
  assign unused_wdata = ^io_bus.write_data[31:16];
  assign io_bus.read_data = read_data_q;

  always_comb begin
    status_word        = '0;
    status_word[0]     = (state != UART_IDLE);
    status_word[1]     = fifo_full;
    status_word[2]     = fifo_empty;
    status_word[3]     = overflow;
    status_word[15:8]  = 8'(fifo_count);
  end

  always_comb begin
    rd_mux = '0;
    if (sel_status)   rd_mux = status_word;
    else if (sel_div) rd_mux = {16'h0, divisor};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow    <= 1'b0;
      divisor     <= DEFAULT_DIVISOR;
      read_data_q <= '0;
    end else begin
      // A dropped push wins over a same-cycle clear so the loss stays visible.
      if (push_drop)
        overflow <= 1'b1;
      else if (io_bus.write_en && sel_status && io_bus.write_data[3])
        overflow <= 1'b0;
      if (io_bus.write_en && sel_div)
        divisor <= divisor_sanitize(io_bus.write_data[15:0]);
      if (io_bus.read_en)
        read_data_q <= rd_mux;
    end
  end

  assign bit_end  = (bit_cnt == 16'd0);
  assign fifo_pop = !fifo_empty && ((state == UART_IDLE) || (state == UART_STOP && bit_end));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= UART_IDLE;
      uart_tx <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        UART_IDLE, UART_STOP: begin
          if (state == UART_IDLE || bit_end) begin
            if (fifo_pop) begin
              shreg   <= fifo_dout;
              state   <= UART_START;
              uart_tx <= 1'b0;
              bit_cnt <= divisor - 16'd1;
`ifdef UART_TX_PARITY_EN
              parity_bit <= ^fifo_dout;
`endif
            end else begin
              state   <= UART_IDLE;
              uart_tx <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        UART_START: begin
          if (bit_end) begin
            state   <= UART_DATA;
            uart_tx <= shreg[0];
            bit_cnt <= divisor - 16'd1;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        UART_DATA: begin
          if (bit_end) begin
            bit_cnt <= divisor - 16'd1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state   <= UART_PARITY;
              uart_tx <= parity_bit;
`else
              state   <= UART_STOP;
              uart_tx <= 1'b1;
`endif
            end else begin
              shreg   <= shreg >> 1;
              uart_tx <= shreg[1];
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        UART_PARITY: begin
          if (bit_end) begin
            state   <= UART_STOP;
            uart_tx <= 1'b1;
            bit_cnt <= divisor - 16'd1;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
`endif
        default: begin
          state   <= UART_IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx: register vector table plus frame-level sequences.
module tb_io_uart_tx;
  import io_uart_tx_pkg::*;

  localparam logic [31:0] BASE     = 32'h40;
  localparam logic [31:0] A_STATUS = BASE + UART_STATUS;
  localparam logic [31:0] A_TX     = BASE + UART_TX_DATA;
  localparam logic [31:0] A_DIV    = BASE + UART_DIVISOR;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_tx;
  int   n_cmp = 0;
  int   n_fail = 0;

  io_bus_interface bus();

  io_uart_tx #(
    .BASE_ADDRESS    (BASE),
    .FIFO_DEPTH      (8),
    .DEFAULT_DIVISOR (16'd434)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .io_bus  (bus),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.write_en   = 1'b1;
    bus.address    = a;
    bus.write_data = d;
    @(negedge clk);
    bus.write_en   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.read_en = 1'b1;
    bus.address = a;
    @(negedge clk);
    bus.read_en = 1'b0;
    d = bus.read_data;
  endtask

  task automatic capture(input int unsigned n, output logic [127:0] v);
    v = '1;
    for (int unsigned i = 0; i < n; i++) begin
      v[i] = uart_tx;
      @(negedge clk);
    end
  endtask

  function automatic int unsigned flen(input int unsigned d0, input int unsigned d);
    return d0 + d * (PAR ? 10 : 9);
  endfunction

  // Bit k of the result is the expected line level k cycles after the start bit begins.
  function automatic logic [127:0] exp_frame(input logic [7:0] b, input int unsigned d0,
                                             input int unsigned d);
    logic [127:0] f = '1;
    int unsigned  k = 0;
    for (int unsigned i = 0; i < d0; i++) begin f[k] = 1'b0; k++; end
    for (int unsigned j = 0; j < 8; j++)
      for (int unsigned i = 0; i < d; i++) begin f[k] = b[j]; k++; end
    if (PAR)
      for (int unsigned i = 0; i < d; i++) begin f[k] = ^b; k++; end
    for (int unsigned i = 0; i < d; i++) begin f[k] = 1'b1; k++; end
    return f;
  endfunction

  initial begin
    vec_t         vecs[16];
    logic [31:0]  rd;
    logic [127:0] v;
    logic [7:0]   ob[10];

    vecs[0]  = '{1'b0, A_STATUS,     32'h0,        32'h4};
    vecs[1]  = '{1'b0, A_DIV,        32'h0,        32'd434};
    vecs[2]  = '{1'b0, A_TX,         32'h0,        32'h0};
    vecs[3]  = '{1'b0, 32'h7C,       32'h0,        32'h0};
    vecs[4]  = '{1'b0, BASE + 32'hC, 32'h0,        32'h0};
    vecs[5]  = '{1'b0, 32'h0,        32'h0,        32'h0};
    vecs[6]  = '{1'b1, A_DIV,        32'h0,        32'h0};
    vecs[7]  = '{1'b0, A_DIV,        32'h0,        32'h1};
    vecs[8]  = '{1'b1, A_DIV,        32'hFFFF2345, 32'h0};
    vecs[9]  = '{1'b0, A_DIV,        32'h0,        32'h2345};
    vecs[10] = '{1'b1, 32'h50,       32'h7,        32'h0};
    vecs[11] = '{1'b0, A_DIV,        32'h0,        32'h2345};
    vecs[12] = '{1'b1, A_STATUS,     32'hFFFFFFF7, 32'h0};
    vecs[13] = '{1'b0, A_STATUS,     32'h0,        32'h4};
    vecs[14] = '{1'b1, A_DIV,        32'h4,        32'h0};
    vecs[15] = '{1'b0, A_DIV,        32'h0,        32'h4};

    ob = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};

    bus.write_en = 1'b0; bus.read_en = 1'b0; bus.address = '0; bus.write_data = '0;
    repeat (3) @(negedge clk);
    check("rst_uart_tx", 128'(uart_tx), 128'(1));
    check("rst_read_data", 128'(bus.read_data), 128'(0));
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      else begin
        bus_read(vecs[i].addr, rd);
        check($sformatf("vec%0d_rd_%0h", i, vecs[i].addr), 128'(rd), 128'(vecs[i].exp));
      end
    end
    repeat (3) @(negedge clk);
    check("read_data_hold", 128'(bus.read_data), 128'(4));

    // Single frame 0x55 at DIVISOR=4, start bit two cycles after the write.
    bus_write(A_TX, 32'h55);
    check("latency_still_idle", 128'(uart_tx), 128'(1));
    @(negedge clk);
    capture(flen(4, 4), v);
    check("frame_55", v, exp_frame(8'h55, 4, 4));
    bus_read(A_STATUS, rd);
    check("status_after_55", 128'(rd), 128'(4));

    // Busy transmitter plus nine more writes: eight queue, the last is dropped.
    fork
      begin
        for (int i = 0; i < 10; i++) bus_write(A_TX, 32'(ob[i]));
        bus_read(A_STATUS, rd);
        check("status_overflow", 128'(rd), 128'(32'h080B));
        bus_write(A_STATUS, 32'h8);
        bus_read(A_STATUS, rd);
        check("status_ovf_cleared", 128'(rd), 128'(32'h0803));
      end
      begin
        logic [127:0] fv;
        repeat (2) @(negedge clk);
        for (int f = 0; f < 9; f++) begin
          capture(flen(4, 4), fv);
          check($sformatf("ovf_frame%0d", f), fv, exp_frame(ob[f], 4, 4));
        end
        capture(8, fv);
        check("ovf_idle_after", fv, '1);
      end
    join
    bus_read(A_STATUS, rd);
    check("status_after_ovf", 128'(rd), 128'(4));

    // DIVISOR change during the start bit: start stays 4, later bits take 8.
    fork
      begin
        bus_write(A_TX, 32'h0F);
        @(negedge clk);
        bus_write(A_DIV, 32'h8);
      end
      begin
        logic [127:0] fv;
        repeat (2) @(negedge clk);
        capture(flen(4, 8), fv);
        check("frame_div_change", fv, exp_frame(8'h0F, 4, 8));
      end
    join
    bus_write(A_DIV, 32'h4);

    // Reset during data bit 3 with a second byte queued.
    bus_write(A_TX, 32'h33);
    bus_write(A_TX, 32'h44);
    repeat (17) @(negedge clk);
    check("mid_frame_bit3", 128'(uart_tx), 128'(0));
    reset = 1'b1;
    @(negedge clk);
    check("reset_tx_high", 128'(uart_tx), 128'(1));
    reset = 1'b0;
    bus_read(A_STATUS, rd);
    check("reset_status", 128'(rd), 128'(4));
    bus_read(A_DIV, rd);
    check("reset_divisor", 128'(rd), 128'(434));
    capture(60, v);
    check("reset_no_frame", v, '1);

    // Parity build sends 11 bits; default build sends 10.
    bus_write(A_DIV, 32'h2);
    bus_write(A_TX, 32'h07);
    @(negedge clk);
    capture(flen(2, 2), v);
    check("frame_07_div2", v, exp_frame(8'h07, 2, 2));
    bus_read(A_STATUS, rd);
    check("status_after_07", 128'(rd), 128'(4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
